unidade_desvio_pilha: RTL and testbench
=======================================

// Module: unidade_desvio_pilha
// PURPOSE
//  Next-PC unit of the processor fetch path; parametrised successor of the branch control unit.
//  Registers the program counter each clock and selects increment, conditional branch (EQ/NE),
//  jump, call/return through an internal return-address stack (RAS), halt and hold.
//  Adds stall input, halt/resume FSM and sticky stack-error flags.
// PARAMETERS
//  ADDR_W       32  PC / target width in bits
//  RAS_DEPTH    8   return-address stack entries (>=1)
//  RESET_VECTOR 0   PC value loaded on Reset
// PORTS
//  clock         in   1          single clock, all state updates on posedge
//  Reset         in   1          synchronous, active-high; wins over every other input
//  habilita      in   1          1 = advance; 0 = stall (all state held)
//  comando       in   3          operation code, see BEHAVIOUR
//  ZeroFlag      in   1          ALU zero result, qualifies BEQ/BNE
//  imediato      in   ADDR_W     branch/call target
//  saidaULA      in   ADDR_W     jump target from ALU
//  continuar     in   1          resume request while HALTED
//  saida         out  ADDR_W     registered PC
//  parado        out  1          1 while FSM in HALTED
//  pilha_vazia   out  1          RAS empty (sp == 0)
//  pilha_cheia   out  1          RAS full (sp == RAS_DEPTH)
//  erro_estouro  out  1          sticky: CALL issued with RAS full
//  erro_vazio    out  1          sticky: RET issued with RAS empty
// BEHAVIOUR
//  Reset (sync): saida=RESET_VECTOR, FSM=RUN, sp=0, parado=0, pilha_vazia=1, pilha_cheia=0,
//   erro_estouro=0, erro_vazio=0. Reset mid-HALT or mid-stall returns to RUN.
//  All outputs registered; a command sampled at edge N is reflected on saida after edge N (1 cycle).
//  habilita=0: PC, sp, RAS contents, FSM, flags all held; comando/continuar ignored.
//  FSM RUN, habilita=1 (PC+1 is modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0):
//   000 INC  saida <= saida+1
//   001 BEQ  saida <= ZeroFlag ? imediato : saida+1
//   010 BNE  saida <= !ZeroFlag ? imediato : saida+1
//   011 JMP  saida <= saidaULA
//   100 CALL if !cheia: RAS[sp] <= saida+1, sp++; saida <= imediato.
//            if cheia: no push, erro_estouro <= 1, saida <= imediato (jump still taken)
//   101 RET  if !vazia: saida <= RAS[sp-1], sp--. if vazia: erro_vazio <= 1, saida <= saida+1
//   110 HALT saida held, FSM -> HALTED, parado <= 1
//   111 HOLD saida held, FSM stays RUN
//  FSM HALTED, habilita=1: comando ignored, saida held; continuar=1 -> RUN, parado <= 0,
//   saida <= saida+1 on the same edge (execution resumes after the HALT). continuar ignored in RUN.
//  Error flags clear only on Reset. sp width = $clog2(RAS_DEPTH+1); sp never exceeds RAS_DEPTH
//   nor underflows. pilha_vazia/pilha_cheia derived from registered sp.
//  RAS contents not reset (only sp); no read of stale entries is possible since pop needs sp>0.
// STRUCTURE
//  Package desvio_pkg: opcode localparams (OP_INC..OP_HOLD, 3-bit), FSM state enum {RUN, HALTED}.
//  Sub-module pilha_retorno #(ADDR_W, RAS_DEPTH): LIFO with push/pop/data_in, topo, vazia, cheia,
//   sync Reset clearing sp; push and pop never asserted together by the parent.
//  Top: PC register, next-PC mux, FSM, sticky error flags.
// TESTING
//  Reset held 2 cycles with comando=001,ZeroFlag=1 -> saida=0, parado=0, vazia=1, errors 0.
//  From PC=10: BEQ Z=1 imediato=40 -> 40; BNE Z=1 -> 41; JMP saidaULA=7 -> 7; INC at 2^ADDR_W-1 -> 0.
//  RAS_DEPTH=2: CALL@5->20, CALL@20->30, CALL@30->50 -> erro_estouro=1, cheia=1, saida=50;
//   RET -> 31? no: RET -> 21, RET -> 6, RET -> erro_vazio=1, saida=7.
//  HALT at PC=12 -> parado=1, saida=12 held 5 cycles with random comando; continuar=1 -> saida=13, parado=0.
//  habilita=0 for 3 cycles with comando=100 -> saida, sp, flags unchanged; habilita=1 -> call executes once.
//  Reset asserted while HALTED with sp=2 -> next cycle saida=RESET_VECTOR, parado=0, vazia=1.

Source files
------------

// File: rtl/desvio_pkg.sv
// Shared opcodes and FSM state encoding for the next-PC unit.
package desvio_pkg;

   localparam logic [2:0] OP_INC  = 3'b000;
   localparam logic [2:0] OP_BEQ  = 3'b001;
   localparam logic [2:0] OP_BNE  = 3'b010;
   localparam logic [2:0] OP_JMP  = 3'b011;
   localparam logic [2:0] OP_CALL = 3'b100;
   localparam logic [2:0] OP_RET  = 3'b101;
   localparam logic [2:0] OP_HALT = 3'b110;
   localparam logic [2:0] OP_HOLD = 3'b111;

   typedef enum logic {RUN, HALTED} estado_t;

endpackage

// File: rtl/pilha_retorno.sv
// Return-address LIFO; only the stack pointer is reset, entries above sp are never read.
// Push on full / pop on empty are ignored so sp stays within 0..RAS_DEPTH.
module pilha_retorno
   import desvio_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int RAS_DEPTH = 8
) (
   input  logic              clock,
   input  logic              Reset,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [ADDR_W-1:0] dado_i,
   output logic [ADDR_W-1:0] topo_o,
   output logic              vazia_o,
   output logic              cheia_o
);

   localparam int SP_W  = $clog2(RAS_DEPTH + 1);
   localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

   logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
   logic [SP_W-1:0]   sp_q;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  rd_idx;

   assign wr_idx  = IDX_W'(sp_q);
   assign rd_idx  = IDX_W'(sp_q - 1'b1);
   assign topo_o  = mem_q[rd_idx];
   assign vazia_o = (sp_q == '0);
   assign cheia_o = (sp_q == SP_W'(RAS_DEPTH));

   always_ff @(posedge clock) begin
      if (push_i && !cheia_o) begin
         mem_q[wr_idx] <= dado_i;
      end
   end

   always_ff @(posedge clock) begin
      if (Reset) begin
         sp_q <= '0;
      end else if (push_i && !cheia_o) begin
         sp_q <= sp_q + 1'b1;
      end else if (pop_i && !vazia_o) begin
         sp_q <= sp_q - 1'b1;
      end
   end

endmodule

// File: rtl/unidade_desvio_pilha.sv
// Next-PC unit: registered PC, branch/jump/call/return selection, halt/resume FSM, sticky stack errors.
// One-cycle latency from command to saida; habilita=0 freezes every piece of state.
module unidade_desvio_pilha
   import desvio_pkg::*;
#(
   parameter int                ADDR_W       = 32,
   parameter int                RAS_DEPTH    = 8,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
   input  logic              clock,
   input  logic              Reset,
   input  logic              habilita,
   input  logic [2:0]        comando,
   input  logic              ZeroFlag,
   input  logic [ADDR_W-1:0] imediato,
   input  logic [ADDR_W-1:0] saidaULA,
   input  logic              continuar,
   output logic [ADDR_W-1:0] saida,
   output logic              parado,
   output logic              pilha_vazia,
   output logic              pilha_cheia,
   output logic              erro_estouro,
   output logic              erro_vazio
);

   estado_t           estado_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] topo;
   logic              parado_q;
   logic              erro_estouro_q;
   logic              erro_vazio_q;
   logic              ativo;
   logic              push;
   logic              pop;

   assign pc_inc = pc_q + 1'b1;
   assign ativo  = habilita && (estado_q == RUN);
   assign push   = ativo && (comando == OP_CALL) && !pilha_cheia;
   assign pop    = ativo && (comando == OP_RET) && !pilha_vazia;

   pilha_retorno #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_pilha (
      .clock   (clock),
      .Reset   (Reset),
      .push_i  (push),
      .pop_i   (pop),
      .dado_i  (pc_inc),
      .topo_o  (topo),
      .vazia_o (pilha_vazia),
      .cheia_o (pilha_cheia)
   );

   always_ff @(posedge clock) begin
      if (Reset) begin
         pc_q           <= RESET_VECTOR;
         estado_q       <= RUN;
         parado_q       <= 1'b0;
         erro_estouro_q <= 1'b0;
         erro_vazio_q   <= 1'b0;
      end else if (habilita) begin
         case (estado_q)
            RUN: begin
               case (comando)
                  OP_INC:  pc_q <= pc_inc;
                  OP_BEQ:  pc_q <= ZeroFlag ? imediato : pc_inc;
                  OP_BNE:  pc_q <= ZeroFlag ? pc_inc : imediato;
                  OP_JMP:  pc_q <= saidaULA;
                  OP_CALL: begin
                     // The jump is taken even when the push is dropped.
                     pc_q <= imediato;
                     if (pilha_cheia) erro_estouro_q <= 1'b1;
                  end
                  OP_RET: begin
                     if (pilha_vazia) begin
                        erro_vazio_q <= 1'b1;
                        pc_q         <= pc_inc;
                     end else begin
                        pc_q <= topo;
                     end
                  end
                  OP_HALT: begin
                     estado_q <= HALTED;
                     parado_q <= 1'b1;
                  end
                  default: ;
               endcase
            end
            HALTED: begin
               if (continuar) begin
                  estado_q <= RUN;
                  parado_q <= 1'b0;
                  pc_q     <= pc_inc;
               end
            end
            default: estado_q <= RUN;
         endcase
      end
   end

   assign saida        = pc_q;
   assign parado       = parado_q;
   assign erro_estouro = erro_estouro_q;
   assign erro_vazio   = erro_vazio_q;

endmodule

// File: tb/tb_unidade_desvio_pilha.sv
// Bench for unidade_desvio_pilha: directed vector table, multi-cycle corner sequences, random run vs queue model.
module tb_unidade_desvio_pilha;

   localparam int AW    = 8;
   localparam int DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst, hab, z, cont;
   logic [2:0]    cmd;
   logic [AW-1:0] imed, ula;
   logic [AW-1:0] saida;
   logic          parado, vazia, cheia, eo, ev;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [AW-1:0] m_pc;
   bit            m_halt, m_eo, m_ev;
   logic [AW-1:0] m_ras[$];

   typedef struct {
      logic          rst, hab;
      logic [2:0]    cmd;
      logic          z;
      logic [AW-1:0] imed, ula;
      logic          cont;
      logic [AW-1:0] e_pc;
      logic          e_par, e_vaz, e_che, e_eo, e_ev;
   } vec_t;

   vec_t tbl[22];

   unidade_desvio_pilha #(
      .ADDR_W       (AW),
      .RAS_DEPTH    (DEPTH),
      .RESET_VECTOR ('0)
   ) dut (
      .clock        (clk),
      .Reset        (rst),
      .habilita     (hab),
      .comando      (cmd),
      .ZeroFlag     (z),
      .imediato     (imed),
      .saidaULA     (ula),
      .continuar    (cont),
      .saida        (saida),
      .parado       (parado),
      .pilha_vazia  (vazia),
      .pilha_cheia  (cheia),
      .erro_estouro (eo),
      .erro_vazio   (ev)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, h, input logic [2:0] c, input logic zz,
                               input logic [AW-1:0] im, ul, input logic co,
                               input logic [AW-1:0] ep, input logic ep1, ev1, ec1, eeo, eev);
      vec_t v;
      v.rst = r;  v.hab = h;  v.cmd = c;  v.z = zz;  v.imed = im;  v.ula = ul;  v.cont = co;
      v.e_pc = ep;  v.e_par = ep1;  v.e_vaz = ev1;  v.e_che = ec1;  v.e_eo = eeo;  v.e_ev = eev;
      return v;
   endfunction

   task automatic check(input string nome, input logic [AW-1:0] got, input logic [AW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nome, got, exp, $time);
      end
   endtask

   function automatic void model_step(input logic r, h, input logic [2:0] c, input logic zz,
                                      input logic [AW-1:0] im, ul, input logic co);
      if (r) begin
         m_pc = '0;  m_halt = 0;  m_eo = 0;  m_ev = 0;  m_ras.delete();
      end else if (h) begin
         if (m_halt) begin
            if (co) begin
               m_halt = 0;
               m_pc   = m_pc + 1'b1;
            end
         end else begin
            case (c)
               3'd0: m_pc = m_pc + 1'b1;
               3'd1: m_pc = zz ? im : m_pc + 1'b1;
               3'd2: m_pc = !zz ? im : m_pc + 1'b1;
               3'd3: m_pc = ul;
               3'd4: begin
                  if (m_ras.size() < DEPTH) m_ras.push_back(m_pc + 1'b1);
                  else m_eo = 1;
                  m_pc = im;
               end
               3'd5: begin
                  if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                  else begin
                     m_ev = 1;
                     m_pc = m_pc + 1'b1;
                  end
               end
               3'd6: m_halt = 1;
               default: ;
            endcase
         end
      end
   endfunction

   task automatic cycle(input logic r, h, input logic [2:0] c, input logic zz,
                        input logic [AW-1:0] im, ul, input logic co);
      @(negedge clk);
      rst = r;  hab = h;  cmd = c;  z = zz;  imed = im;  ula = ul;  cont = co;
      @(posedge clk);
      #1;
      model_step(r, h, c, zz, im, ul, co);
   endtask

   task automatic check_model(input string tag);
      check({tag, ".saida"}, saida, m_pc);
      check({tag, ".parado"}, AW'(parado), AW'(m_halt));
      check({tag, ".vazia"}, AW'(vazia), AW'(m_ras.size() == 0));
      check({tag, ".cheia"}, AW'(cheia), AW'(m_ras.size() == DEPTH));
      check({tag, ".erro_estouro"}, AW'(eo), AW'(m_eo));
      check({tag, ".erro_vazio"}, AW'(ev), AW'(m_ev));
   endtask

   initial begin
      rst = 1'b1;  hab = 1'b1;  cmd = 3'd1;  z = 1'b1;  imed = '0;  ula = '0;  cont = 1'b0;
      m_pc = '0;  m_halt = 0;  m_eo = 0;  m_ev = 0;

      //          rst hab cmd zf imed ula cont | pc  par vaz che eo ev
      tbl[0]  = mk(1, 1, 3'd1, 1,  55,  0, 0,    0,  0,  1,  0,  0, 0);
      tbl[1]  = mk(1, 1, 3'd1, 1,  55,  0, 0,    0,  0,  1,  0,  0, 0);
      tbl[2]  = mk(0, 1, 3'd3, 0,   0, 10, 0,   10,  0,  1,  0,  0, 0);
      tbl[3]  = mk(0, 1, 3'd1, 1,  40,  0, 0,   40,  0,  1,  0,  0, 0);
      tbl[4]  = mk(0, 1, 3'd3, 0,   0, 10, 0,   10,  0,  1,  0,  0, 0);
      tbl[5]  = mk(0, 1, 3'd2, 1,  40,  0, 0,   11,  0,  1,  0,  0, 0);
      tbl[6]  = mk(0, 1, 3'd2, 0,  40,  0, 0,   40,  0,  1,  0,  0, 0);
      tbl[7]  = mk(0, 1, 3'd1, 0,  99,  0, 0,   41,  0,  1,  0,  0, 0);
      tbl[8]  = mk(0, 1, 3'd3, 1,   0,  7, 0,    7,  0,  1,  0,  0, 0);
      tbl[9]  = mk(0, 1, 3'd3, 0,   0,255, 0,  255,  0,  1,  0,  0, 0);
      tbl[10] = mk(0, 1, 3'd0, 0,   9,  9, 0,    0,  0,  1,  0,  0, 0);
      tbl[11] = mk(0, 1, 3'd7, 1,   9,  9, 1,    0,  0,  1,  0,  0, 0);
      tbl[12] = mk(0, 1, 3'd3, 0,   0,  5, 0,    5,  0,  1,  0,  0, 0);
      tbl[13] = mk(0, 1, 3'd4, 0,  20,  0, 0,   20,  0,  0,  0,  0, 0);
      tbl[14] = mk(0, 1, 3'd4, 0,  30,  0, 0,   30,  0,  0,  1,  0, 0);
      tbl[15] = mk(0, 1, 3'd4, 0,  50,  0, 0,   50,  0,  0,  1,  1, 0);
      tbl[16] = mk(0, 1, 3'd5, 0,  77,  0, 0,   21,  0,  0,  0,  1, 0);
      tbl[17] = mk(0, 1, 3'd5, 0,  77,  0, 0,    6,  0,  1,  0,  1, 0);
      tbl[18] = mk(0, 1, 3'd5, 0,  77,  0, 0,    7,  0,  1,  0,  1, 1);
      tbl[19] = mk(1, 0, 3'd4, 0,  77,  0, 1,    0,  0,  1,  0,  0, 0);
      tbl[20] = mk(0, 1, 3'd3, 0,   0, 12, 0,   12,  0,  1,  0,  0, 0);
      tbl[21] = mk(0, 1, 3'd6, 1,  90, 91, 0,   12,  1,  1,  0,  0, 0);

      for (int i = 0; i < 22; i++) begin
         cycle(tbl[i].rst, tbl[i].hab, tbl[i].cmd, tbl[i].z, tbl[i].imed, tbl[i].ula, tbl[i].cont);
         check($sformatf("vec%0d.saida", i), saida, tbl[i].e_pc);
         check($sformatf("vec%0d.parado", i), AW'(parado), AW'(tbl[i].e_par));
         check($sformatf("vec%0d.vazia", i), AW'(vazia), AW'(tbl[i].e_vaz));
         check($sformatf("vec%0d.cheia", i), AW'(cheia), AW'(tbl[i].e_che));
         check($sformatf("vec%0d.erro_estouro", i), AW'(eo), AW'(tbl[i].e_eo));
         check($sformatf("vec%0d.erro_vazio", i), AW'(ev), AW'(tbl[i].e_ev));
      end

      // halted: comando ignored for 5 cycles, then resume after the HALT
      for (int i = 0; i < 5; i++) begin
         cycle(0, 1, 3'($urandom_range(0, 7)), 1'($urandom), AW'($urandom), AW'($urandom), 0);
         check("halt_hold.saida", saida, 8'd12);
         check("halt_hold.parado", AW'(parado), 8'd1);
      end
      cycle(0, 1, 3'd3, 0, 8'd200, 8'd201, 1);
      check("resume.saida", saida, 8'd13);
      check("resume.parado", AW'(parado), 8'd0);
      check_model("resume");

      // continuar is ignored while running
      cycle(0, 1, 3'd7, 0, 0, 0, 1);
      check("cont_in_run.saida", saida, 8'd13);

      // stall with a pending CALL, then exactly one CALL
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 3'd4, 1'($urandom), 8'd60, 8'd61, 1'($urandom));
         check("stall.saida", saida, 8'd13);
         check("stall.vazia", AW'(vazia), 8'd1);
         check_model("stall");
      end
      cycle(0, 1, 3'd4, 0, 8'd60, 0, 0);
      check("stall_release.saida", saida, 8'd60);
      check("stall_release.vazia", AW'(vazia), 8'd0);
      cycle(0, 1, 3'd7, 0, 8'd60, 0, 0);
      check("call_once.saida", saida, 8'd60);
      check_model("call_once");

      // fill the stack, halt, stall with continuar, then reset while halted
      cycle(0, 1, 3'd4, 0, 8'd70, 0, 0);
      check("fill.cheia", AW'(cheia), 8'd1);
      cycle(0, 1, 3'd6, 0, 0, 0, 0);
      cycle(0, 0, 3'd0, 0, 0, 0, 1);
      check("halt_stall.parado", AW'(parado), 8'd1);
      check("halt_stall.saida", saida, 8'd70);
      cycle(1, 1, 3'd0, 0, 0, 0, 0);
      check("rst_halt.saida", saida, 8'd0);
      check("rst_halt.parado", AW'(parado), 8'd0);
      check("rst_halt.vazia", AW'(vazia), 8'd1);
      check_model("rst_halt");

      // random run against the queue model
      for (int i = 0; i < 600; i++) begin
         cycle(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 4) != 0),
               3'($urandom_range(0, 7)), 1'($urandom), AW'($urandom), AW'($urandom),
               1'($urandom_range(0, 2) == 0));
         check_model("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
